// File: rtl/gerador_pisca_leds.sv
// LED-blink responder for the control unit: times the on/off phases, counts
// blinks, drives the LED pattern from a latched mask and flags handshake misuse.
module gerador_pisca_leds #(
  parameter int T_ON       = 500,
  parameter int T_OFF      = 500,
  parameter int N_PISCADAS = 3,
  parameter int LED_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zeraPisca,
  input  logic             registraMascara,
  input  logic [LED_W-1:0] mascara,
  input  logic             contaLedsOn,
  input  logic             contaLedsOff,
  output logic             fimLedsOn,
  output logic             fimLedsOff,
  output logic             fimPiscaLeds,
  output logic [LED_W-1:0] leds,
  output logic [1:0]       db_fase,
  output logic             db_erro
);

  localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int CW    = $clog2(T_MAX + 1);
  localparam int PW    = $clog2(N_PISCADAS + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(T_ON - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(T_OFF - 1);
  localparam logic [PW-1:0] P_MAX    = PW'(N_PISCADAS);
  localparam logic [PW-1:0] P_LAST   = PW'(N_PISCADAS - 1);

  typedef enum logic [1:0] {
    ESPERA    = 2'b00,
    ACESO     = 2'b01,
    APAGADO   = 2'b10,
    CONCLUIDO = 2'b11
  } fase_t;

  fase_t            state_q, state_d;
  logic [CW-1:0]    cnt_on_q, cnt_on_d;
  logic [CW-1:0]    cnt_off_q, cnt_off_d;
  logic [PW-1:0]    cnt_p_q, cnt_p_d;
  logic [LED_W-1:0] mask_q, mask_d;
  logic [LED_W-1:0] leds_q, leds_d;
  logic             erro_q, erro_d;
  // Set once a sequence is started (zeraPisca or any on-cycle); keeps
  // fimPiscaLeds low straight out of reset even when N_PISCADAS=1.
  logic             armado_q, armado_d;

  logic so_on, so_off, violacao;

  // Handshake decode and combinational completion flags
  always_comb begin
    so_on        = contaLedsOn && !contaLedsOff;
    so_off       = contaLedsOff && !contaLedsOn;
    fimLedsOn    = !reset && so_on && (cnt_on_q == ON_LAST);
    fimLedsOff   = !reset && so_off && (cnt_off_q == OFF_LAST);
    fimPiscaLeds = !reset && (cnt_p_q >= P_LAST) && (armado_q || contaLedsOn);
    violacao     = (contaLedsOn && contaLedsOff)
                || (contaLedsOff && (state_q == ESPERA || state_q == CONCLUIDO))
                || (contaLedsOn && (state_q == APAGADO || state_q == CONCLUIDO));
  end

  // Next-state: counters, phase FSM, mask, error flag and LED drive
  always_comb begin
    state_d   = state_q;
    cnt_on_d  = cnt_on_q;
    cnt_off_d = cnt_off_q;
    cnt_p_d   = cnt_p_q;
    mask_d    = mask_q;
    erro_d    = erro_q;
    armado_d  = armado_q;
    leds_d    = (state_q == ACESO || state_q == CONCLUIDO) ? mask_q : '0;

    if (zeraPisca) begin
      state_d   = ESPERA;
      cnt_on_d  = '0;
      cnt_off_d = '0;
      cnt_p_d   = '0;
      erro_d    = 1'b0;
      armado_d  = 1'b1;
    end else begin
      if (contaLedsOn)
        armado_d = 1'b1;
      if (violacao)
        erro_d = 1'b1;

      if (so_on)
        cnt_on_d = fimLedsOn ? '0 : cnt_on_q + CW'(1);
      else if (!contaLedsOn)
        cnt_on_d = '0;

      if (so_off)
        cnt_off_d = fimLedsOff ? '0 : cnt_off_q + CW'(1);
      else if (!contaLedsOff)
        cnt_off_d = '0;

      if (fimLedsOn && cnt_p_q != P_MAX)
        cnt_p_d = cnt_p_q + PW'(1);

      // With T_ON=1 the phase can end on its very first cycle, while still in
      // ESPERA, so that state resolves the end of phase directly as well.
      unique case (state_q)
        ESPERA: begin
          if (contaLedsOn) begin
            if (fimLedsOn)
              state_d = fimPiscaLeds ? CONCLUIDO : APAGADO;
            else
              state_d = ACESO;
          end
        end
        ACESO: begin
          if (fimLedsOn)
            state_d = fimPiscaLeds ? CONCLUIDO : APAGADO;
        end
        APAGADO: begin
          if (fimLedsOff)
            state_d = ACESO;
        end
        CONCLUIDO: state_d = CONCLUIDO;
        default:   state_d = ESPERA;
      endcase
    end

    if (registraMascara)
      mask_d = mascara;
  end

  // State and registered outputs, asynchronous active-high reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ESPERA;
      cnt_on_q  <= '0;
      cnt_off_q <= '0;
      cnt_p_q   <= '0;
      mask_q    <= '0;
      leds_q    <= '0;
      erro_q    <= 1'b0;
      armado_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_on_q  <= cnt_on_d;
      cnt_off_q <= cnt_off_d;
      cnt_p_q   <= cnt_p_d;
      mask_q    <= mask_d;
      leds_q    <= leds_d;
      erro_q    <= erro_d;
      armado_q  <= armado_d;
    end
  end

  assign leds    = leds_q;
  assign db_fase = state_q;
  assign db_erro = erro_q;

endmodule

// File: tb/tb_gerador_pisca_leds.sv
// Directed bench for gerador_pisca_leds: main instance T_ON=4/T_OFF=3/N=2,
// a second instance T_ON=1/T_OFF=1/N=1 for the single-cycle edge case.
module tb_gerador_pisca_leds;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       zeraPisca = 1'b0;
  logic       registraMascara = 1'b0;
  logic [3:0] mascara = '0;
  logic       contaLedsOn = 1'b0;
  logic       contaLedsOff = 1'b0;

  logic       fim_on0, fim_off0, fim_p0, erro0;
  logic [3:0] leds0;
  logic [1:0] fase0;
  logic       fim_on1, fim_off1, fim_p1, erro1;
  logic [3:0] leds1;
  logic [1:0] fase1;

  gerador_pisca_leds #(.T_ON(4), .T_OFF(3), .N_PISCADAS(2), .LED_W(4)) dut (
    .clock(clock), .reset(reset), .zeraPisca(zeraPisca),
    .registraMascara(registraMascara), .mascara(mascara),
    .contaLedsOn(contaLedsOn), .contaLedsOff(contaLedsOff),
    .fimLedsOn(fim_on0), .fimLedsOff(fim_off0), .fimPiscaLeds(fim_p0),
    .leds(leds0), .db_fase(fase0), .db_erro(erro0)
  );

  gerador_pisca_leds #(.T_ON(1), .T_OFF(1), .N_PISCADAS(1), .LED_W(4)) dut_min (
    .clock(clock), .reset(reset), .zeraPisca(zeraPisca),
    .registraMascara(registraMascara), .mascara(mascara),
    .contaLedsOn(contaLedsOn), .contaLedsOff(contaLedsOff),
    .fimLedsOn(fim_on1), .fimLedsOff(fim_off1), .fimPiscaLeds(fim_p1),
    .leds(leds1), .db_fase(fase1), .db_erro(erro1)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic expect_v(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_v(input logic [7:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic drive(input logic on, input logic off, input logic zera,
                       input logic regm, input logic [3:0] m);
    contaLedsOn     = on;
    contaLedsOff    = off;
    zeraPisca       = zera;
    registraMascara = regm;
    mascara         = m;
  endtask

  // Advance one clock; inputs change and outputs are sampled away from the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic zera();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  // n on-cycles; fimLedsOn expected only on cycle fim_at, with fimPiscaLeds=pisca there
  task automatic phase_on(input int n, input int fim_at, input logic pisca, input string tag);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      expect_v({tag, "_fimLedsOn"}, {7'd0, k == fim_at});
      if (k == fim_at) expect_v({tag, "_fimPiscaLeds"}, {7'd0, pisca});
      #2;
      check_v({7'd0, fim_on0});
      if (k == fim_at) check_v({7'd0, fim_p0});
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic phase_off(input int n, input int fim_at, input string tag);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      expect_v({tag, "_fimLedsOff"}, {7'd0, k == fim_at});
      #2;
      check_v({7'd0, fim_off0});
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    // Reset state
    #2;
    expect_v("rst_leds", 8'h00);  check_v({4'd0, leds0});
    expect_v("rst_fase", 8'h00);  check_v({6'd0, fase0});
    expect_v("rst_erro", 8'h00);  check_v({7'd0, erro0});
    expect_v("rst_fims", 8'h00);  check_v({5'd0, fim_on0, fim_off0, fim_p0});
    tick();
    reset = 1'b0;
    tick();

    // 1. Nominal sequence with mask 1010
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1010);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      expect_v("nom_on1_fim", {7'd0, k == 3});
      if (k == 3) expect_v("nom_on1_pisca", 8'h00);
      if (k == 2) expect_v("nom_on1_leds", 8'h0A);
      #2;
      check_v({7'd0, fim_on0});
      if (k == 3) check_v({7'd0, fim_p0});
      if (k == 2) check_v({4'd0, leds0});
      tick();
    end
    expect_v("nom_fase_apagado", 8'h02); check_v({6'd0, fase0});
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      expect_v("nom_off_fim", {7'd0, k == 2});
      if (k == 1) expect_v("nom_off_leds", 8'h00);
      #2;
      check_v({7'd0, fim_off0});
      if (k == 1) check_v({4'd0, leds0});
      tick();
    end
    expect_v("nom_fase_aceso2", 8'h01); check_v({6'd0, fase0});
    phase_on(4, 3, 1'b1, "nom_on2");
    #2;
    expect_v("nom_fase_concluido", 8'h03); check_v({6'd0, fase0});
    expect_v("nom_leds_final", 8'h0A);     check_v({4'd0, leds0});
    expect_v("nom_erro", 8'h00);           check_v({7'd0, erro0});

    // 2. Phase restart after a one-cycle drop
    zera();
    phase_on(2, -1, 1'b0, "rst2_a");
    tick();
    phase_on(4, 3, 1'b0, "rst2_b");
    expect_v("rst2_erro", 8'h00); check_v({7'd0, erro0});

    // 3. Protocol violation: both requests high holds the counter
    zera();
    phase_on(2, -1, 1'b0, "viol_a");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    expect_v("viol_both_fim", 8'h00);
    #2;
    check_v({7'd0, fim_on0});
    tick();
    expect_v("viol_erro_set", 8'h01); check_v({7'd0, erro0});
    phase_on(2, 1, 1'b0, "viol_b");
    expect_v("viol_erro_sticky", 8'h01); check_v({7'd0, erro0});
    zera();
    expect_v("viol_erro_clr", 8'h00); check_v({7'd0, erro0});
    expect_v("viol_fase_clr", 8'h00); check_v({6'd0, fase0});

    // 5. Mask update while lit; counters undisturbed
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
    expect_v("mask_fim1", 8'h00);
    #2;
    check_v({7'd0, fim_on0});
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    expect_v("mask_leds_old", 8'h0A); check_v({4'd0, leds0});
    tick();
    expect_v("mask_leds_new", 8'h06); check_v({4'd0, leds0});
    expect_v("mask_fim4", 8'h01);
    expect_v("mask_pisca", 8'h00);
    #2;
    check_v({7'd0, fim_on0});
    check_v({7'd0, fim_p0});
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // 4. Reset in the second on-phase with cntOn=2
    zera();
    phase_on(4, 3, 1'b0, "mid_on1");
    phase_off(3, 2, "mid_off");
    phase_on(2, -1, 1'b1, "mid_on2");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    #1;
    reset = 1'b1;
    #1;
    expect_v("mid_rst_leds", 8'h00); check_v({4'd0, leds0});
    expect_v("mid_rst_fase", 8'h00); check_v({6'd0, fase0});
    expect_v("mid_rst_fims", 8'h00); check_v({5'd0, fim_on0, fim_off0, fim_p0});
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    reset = 1'b0;
    #2;
    expect_v("post_rst_fims", 8'h00); check_v({5'd0, fim_on0, fim_off0, fim_p0});
    tick();
    phase_on(4, 3, 1'b0, "post_rst_on");

    // 6. T_ON=1, N_PISCADAS=1 instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    expect_v("min_pisca_after_reset", 8'h00); check_v({7'd0, fim_p1});
    zera();
    expect_v("min_pisca_after_zera", 8'h01); check_v({7'd0, fim_p1});
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    expect_v("min_fimLedsOn", 8'h01);
    expect_v("min_fimPisca", 8'h01);
    #2;
    check_v({7'd0, fim_on1});
    check_v({7'd0, fim_p1});
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    expect_v("min_fase_concluido", 8'h03); check_v({6'd0, fase1});
    expect_v("min_erro", 8'h00);           check_v({7'd0, erro1});

    if (sb.size() != 0) begin
      n_errors++;
      $error("FAIL scoreboard_leftover: observed %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gerador_pisca_leds.md
Name: gerador_pisca_leds

Overview:
Datapath-side responder for the control unit's LED-blink handshake. The control unit's blink states drive contaLedsOn/contaLedsOff. This block times each phase and returns fimLedsOn, fimLedsOff and fimPiscaLeds. It also drives the LED pattern (latched hit mask while lit, dark while off) and flags protocol violations for debug.

Parameters:
T_ON, 500, on-phase length in clock cycles (>=1)
T_OFF, 500, off-phase length in clock cycles (>=1)
N_PISCADAS, 3, number of on-phases per blink sequence (>=1)
LED_W, 4, LED/mask width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; clock clock
zeraPisca  in  1  sync clear of counters, internal state and db_erro (asserted by control unit before a blink sequence)
registraMascara  in  1  load mascara into internal mask register
mascara  in  LED_W  hit pattern to display
contaLedsOn  in  1  control unit is in on-phase; advance on counter
contaLedsOff  in  1  control unit is in off-phase; advance off counter
fimLedsOn  out  1  on-phase complete
fimLedsOff  out  1  off-phase complete
fimPiscaLeds  out  1  current/last on-phase is the final one
leds  out  LED_W  LED drive
db_fase  out  2  internal state code
db_erro  out  1  sticky protocol-violation flag

Behaviour:
- Reset: all counters 0, mask 0, state ESPERA, leds=0, db_erro=0. All fim outputs 0.
- Counters: cntOn and cntOff are $clog2(max(T_ON,T_OFF)+1) bits. cntP is $clog2(N_PISCADAS+1) bits.
- Priority, per cycle: reset > zeraPisca > registraMascara (independent, same cycle allowed) > counting.
- zeraPisca: next cycle cntOn=cntOff=cntP=0, state ESPERA, db_erro=0. Mask is retained.
- registraMascara: mask<=mascara, next edge.
- Internal FSM (db_fase): ESPERA=00, ACESO=01, APAGADO=10, CONCLUIDO=11.
  - ESPERA -> ACESO when contaLedsOn.
  - ACESO -> APAGADO when fimLedsOn and !fimPiscaLeds.
  - ACESO -> CONCLUIDO when fimLedsOn and fimPiscaLeds.
  - APAGADO -> ACESO when fimLedsOff.
  - CONCLUIDO -> ESPERA only on zeraPisca.
- On counting: while contaLedsOn && !contaLedsOff, cntOn increments each cycle. When contaLedsOn is low, cntOn resets to 0 next cycle, so each phase restarts from 0.
- fimLedsOn (combinational) = contaLedsOn && !contaLedsOff && cntOn==T_ON-1. It is high exactly on the T_ON-th cycle of contaLedsOn.
  - On that cycle cntOn wraps to 0 and cntP increments, saturating at N_PISCADAS.
- Off counting mirrors on counting: cntOff, contaLedsOff, T_OFF. fimLedsOff = contaLedsOff && !contaLedsOn && cntOff==T_OFF-1. cntP is unaffected by the off phase.
- fimPiscaLeds (combinational) = (cntP >= N_PISCADAS-1). The control unit samples it together with fimLedsOn.
- leds (registered): mask in ACESO or CONCLUIDO; 0 in APAGADO and ESPERA.
  - Registered output lags the state by one cycle.
  - Entry into ACESO is on the edge after the first contaLedsOn cycle. leds shows mask one cycle after that.
- db_erro is set (sticky until zeraPisca or reset) on any of:
  - contaLedsOn && contaLedsOff in the same cycle. Neither counter advances that cycle.
  - contaLedsOff while state ESPERA or CONCLUIDO.
  - contaLedsOn while state APAGADO.
  - contaLedsOn while state CONCLUIDO.
- Reset mid-sequence: immediate return to reset values. No fim output may be asserted in the cycle after reset deasserts.
- T_ON=1: fimLedsOn is high on the first contaLedsOn cycle.
- N_PISCADAS=1: fimPiscaLeds=1 from zeraPisca onward.

Test Plan:
All scenarios use T_ON=4, T_OFF=3, N_PISCADAS=2, LED_W=4 unless stated.
1. Nominal: zeraPisca, registraMascara with mascara=4'b1010, then emulate the control unit.
   - Expect fimLedsOn on the 4th on-cycle with fimPiscaLeds=0.
   - Then fimLedsOff on the 3rd off-cycle.
   - Second on-phase: fimLedsOn on its 4th cycle with fimPiscaLeds=1; state CONCLUIDO (db_fase=11).
   - leds: 1010 / 0000 / 1010 pattern; db_erro=0.
2. Phase restart: contaLedsOn for 2 cycles, drop 1 cycle, reassert. fimLedsOn only after 4 further consecutive cycles.
3. Protocol violation: contaLedsOn=contaLedsOff=1 for 1 cycle -> db_erro=1 and stays 1. No counter advance. zeraPisca clears it next cycle.
4. Reset mid-sequence: assert reset during the second on-phase (cntOn=2) -> leds=0, db_fase=00, fim outputs 0.
   - Next sequence times a full 4 cycles for the on-phase.
5. Mask update: registraMascara with 4'b0110 while in ACESO -> leds=0110 from the following cycle. The counters are not disturbed.
6. Edge parameters: T_ON=1, N_PISCADAS=1 -> fimLedsOn and fimPiscaLeds both high on the first contaLedsOn cycle; state CONCLUIDO.
